keypad_entry_scanner: RTL and testbench

- Parametrised matrix-keypad scanner with press/release debounce and a digit-entry buffer of configurable depth.
- Successor of the fixed 4x4 / 20-digit keypad decoder, adding:
  - backspace and digit count;
  - timeout only while entry is pending;
  - release debounce;
  - fully registered posedge outputs.
- Sits between the physical keypad pins and the password/lock controller, which consumes digits_value on digits_valid.

---
 rtl/keypad_entry_scanner.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_keypad_entry_scanner.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner
//   Scans a ROWS x COLS active-low matrix keypad, debounces both press and
//   release, and collects digits into a shift buffer (slot 0 = newest) that
//   the lock controller takes when digits_valid pulses.
//
// Ports
//   clk, rst      clock (posedge) and asynchronous active-high reset
//   enable        scanning enabled; a drop while a key is in flight takes
//                 effect when that key has been released
//   col_in        column sense, active-low, already synchronised
//   row_out       row drive, one bit low while scanning, all ones when disabled
//   digits_value  MAX_DIGITS 4-bit slots, slot k = [4k+3:4k]
//   digits_count  number of valid digits in the buffer
//   digits_valid  completed-entry pulse
//   entry_status  00 submit, 01 cancel, 10 timeout (qualified by digits_valid)
//   dbg_state_o   current FSM state (0 scan, 1 debounce, 2 action,
//                 3 release, 4 disabled)
//
// Output handshake: digits_valid is a one-cycle pulse with no ready/back-
// pressure. digits_value and entry_status are stable during that cycle; the
// buffer is cleared on the following clock edge, and two pulses are never
// adjacent.
module keypad_entry_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int MAX_DIGITS   = 20,
    parameter int SCAN_DIV     = 1,
    parameter int DEBOUNCE_CYC = 100,
    parameter int TIMEOUT_CYC  = 5000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [COLS-1:0]                    col_in,
    output logic [ROWS-1:0]                    row_out,
    output logic [4*MAX_DIGITS-1:0]            digits_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    digits_count,
    output logic                               digits_valid,
    output logic [1:0]                         entry_status,
    output logic [2:0]                         dbg_state_o
);

    localparam int RW   = $clog2(ROWS);
    localparam int CLW  = $clog2(COLS);
    localparam int CNTW = $clog2(MAX_DIGITS + 1);
    localparam int DBW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int SDW  = $clog2(SCAN_DIV + 1);
    localparam int TOW  = $clog2(TIMEOUT_CYC + 1);
    localparam int DV   = 4 * MAX_DIGITS;

    localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
    localparam logic [SDW-1:0]  SCAN_LAST = SDW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0]  DEB_ACT   = DBW'(DEBOUNCE_CYC - 2);
    localparam logic [DBW-1:0]  DEB_REL   = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [TOW-1:0]  TO_LAST   = TOW'(TIMEOUT_CYC - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(MAX_DIGITS);
    localparam logic [DV-1:0]   ALL_F     = {MAX_DIGITS{4'hF}};
    localparam logic [DV-1:0]   ALL_B     = {MAX_DIGITS{4'hB}};
    localparam logic [DV-1:0]   ALL_E     = {MAX_DIGITS{4'hE}};

    typedef enum logic [2:0] {
        S_SCAN     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_ACTION   = 3'd2,
        S_RELEASE  = 3'd3,
        S_DISABLED = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        K_NONE, K_DIGIT, K_SUBMIT, K_CANCEL, K_BACK
    } key_kind_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [SDW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [RW-1:0]   key_row_q, key_row_d;
    logic [CLW-1:0]  key_col_q, key_col_d;
    logic [COLS-1:0] col_pat_q, col_pat_d;
    logic [DBW-1:0]  deb_q, deb_d;
    logic [TOW-1:0]  idle_q, idle_d;
    logic            clr_q, clr_d;
    logic [ROWS-1:0] row_out_q, row_out_d;
    logic [DV-1:0]   digits_q, digits_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            valid_q, valid_d;
    logic [1:0]      status_q, status_d;

    logic [COLS-1:0] col_low;
    logic            col_idle;
    logic            col_single;
    logic [CLW-1:0]  col_idx;
    key_kind_t       key_kind;
    logic [3:0]      key_digit;

    assign col_low  = ~col_in;
    assign col_idle = &col_in;
    // Exactly one low column: non-zero and clearing the lowest set bit leaves zero.
    assign col_single = (col_low != '0) && ((col_low & (col_low - COLS'(1))) == '0);

    always_comb begin
        col_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_in[c]) col_idx = CLW'(c);
        end
    end

    // Keys outside the 4x4 legend decode to K_NONE.
    always_comb begin
        key_kind  = K_NONE;
        key_digit = 4'h0;
        if (32'(key_row_q) < 32'd4 && 32'(key_col_q) < 32'd4) begin
            case ({key_row_q[1:0], key_col_q[1:0]})
                4'b00_00: begin key_kind = K_DIGIT; key_digit = 4'd1; end
                4'b00_01: begin key_kind = K_DIGIT; key_digit = 4'd2; end
                4'b00_10: begin key_kind = K_DIGIT; key_digit = 4'd3; end
                4'b01_00: begin key_kind = K_DIGIT; key_digit = 4'd4; end
                4'b01_01: begin key_kind = K_DIGIT; key_digit = 4'd5; end
                4'b01_10: begin key_kind = K_DIGIT; key_digit = 4'd6; end
                4'b10_00: begin key_kind = K_DIGIT; key_digit = 4'd7; end
                4'b10_01: begin key_kind = K_DIGIT; key_digit = 4'd8; end
                4'b10_10: begin key_kind = K_DIGIT; key_digit = 4'd9; end
                4'b11_00: key_kind = K_SUBMIT;
                4'b11_01: begin key_kind = K_DIGIT; key_digit = 4'd0; end
                4'b11_10: key_kind = K_CANCEL;
                4'b11_11: key_kind = K_BACK;
                default:  key_kind = K_NONE;
            endcase
        end
    end

    // State register (all outputs are registered here too).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_SCAN;
            row_idx_q  <= '0;
            scan_cnt_q <= '0;
            key_row_q  <= '0;
            key_col_q  <= '0;
            col_pat_q  <= '1;
            deb_q      <= '0;
            idle_q     <= '0;
            clr_q      <= 1'b0;
            row_out_q  <= ~ROWS'(1);
            digits_q   <= ALL_F;
            count_q    <= '0;
            valid_q    <= 1'b0;
            status_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            scan_cnt_q <= scan_cnt_d;
            key_row_q  <= key_row_d;
            key_col_q  <= key_col_d;
            col_pat_q  <= col_pat_d;
            deb_q      <= deb_d;
            idle_q     <= idle_d;
            clr_q      <= clr_d;
            row_out_q  <= row_out_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            status_q   <= status_d;
        end
    end

    // Next-state logic. enable is only sampled in SCAN and at RELEASE exit,
    // so a key already being handled always finishes its release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SCAN: begin
                if (!enable)         state_d = S_DISABLED;
                else if (col_single) state_d = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                if (col_in != col_pat_q) state_d = S_SCAN;
                else if (deb_q == DEB_ACT) state_d = S_ACTION;
            end
            S_ACTION:  state_d = S_RELEASE;
            S_RELEASE: begin
                if (col_idle && deb_q == DEB_REL) state_d = enable ? S_SCAN : S_DISABLED;
            end
            S_DISABLED: begin
                if (enable) state_d = S_SCAN;
            end
            default: state_d = S_SCAN;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        row_idx_d  = row_idx_q;
        scan_cnt_d = scan_cnt_q;
        key_row_d  = key_row_q;
        key_col_d  = key_col_q;
        col_pat_d  = col_pat_q;
        deb_d      = deb_q;
        idle_d     = idle_q;
        clr_d      = 1'b0;
        digits_d   = digits_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        status_d   = status_q;

        // Cycle after a completed-entry pulse: empty the buffer.
        if (clr_q) begin
            digits_d = ALL_F;
            count_d  = '0;
        end

        case (state_q)
            S_SCAN: begin
                if (enable) begin
                    if (col_single) begin
                        // A key beats a simultaneous timeout.
                        key_row_d  = row_idx_q;
                        key_col_d  = col_idx;
                        col_pat_d  = col_in;
                        deb_d      = '0;
                        scan_cnt_d = '0;
                        idle_d     = '0;
                    end else begin
                        // Multi-key patterns hold the row without advancing.
                        if (col_idle) begin
                            if (scan_cnt_q == SCAN_LAST) begin
                                scan_cnt_d = '0;
                                row_idx_d  = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + RW'(1);
                            end else begin
                                scan_cnt_d = scan_cnt_q + SDW'(1);
                            end
                        end
                        if (count_q != '0 && !clr_q) begin
                            if (idle_q == TO_LAST) begin
                                idle_d   = '0;
                                digits_d = ALL_E;
                                valid_d  = 1'b1;
                                status_d = 2'b10;
                                clr_d    = 1'b1;
                            end else begin
                                idle_d = idle_q + TOW'(1);
                            end
                        end
                    end
                end
            end
            S_DEBOUNCE: begin
                if (col_in == col_pat_q) begin
                    deb_d = deb_q + DBW'(1);
                end else begin
                    deb_d      = '0;
                    scan_cnt_d = '0;
                end
            end
            S_ACTION: begin
                deb_d  = '0;
                idle_d = '0;
                case (key_kind)
                    K_DIGIT: begin
                        digits_d = {digits_q[DV-5:0], key_digit};
                        count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNTW'(1);
                    end
                    K_BACK: begin
                        if (count_q != '0) begin
                            digits_d = {4'hF, digits_q[DV-1:4]};
                            count_d  = count_q - CNTW'(1);
                        end
                    end
                    K_SUBMIT: begin
                        if (count_q != '0) begin
                            valid_d  = 1'b1;
                            status_d = 2'b00;
                            clr_d    = 1'b1;
                        end
                    end
                    K_CANCEL: begin
                        digits_d = ALL_B;
                        valid_d  = 1'b1;
                        status_d = 2'b01;
                        clr_d    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_RELEASE: begin
                if (col_idle) deb_d = (deb_q == DEB_REL) ? '0 : deb_q + DBW'(1);
                else          deb_d = '0;
            end
            S_DISABLED: begin
                if (enable) begin
                    row_idx_d  = '0;
                    scan_cnt_d = '0;
                end
            end
            default: ;
        endcase

        if (count_q == '0) idle_d = '0;

        row_out_d = (state_d == S_DISABLED) ? '1 : ~(ROWS'(1) << row_idx_d);
    end

    assign row_out      = row_out_q;
    assign digits_value = digits_q;
    assign digits_count = count_q;
    assign digits_valid = valid_q;
    assign entry_status = status_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// tb_keypad_entry_scanner
//   Directed bench for keypad_entry_scanner with a behavioural keypad, a
//   queue-based model of the digit buffer and a scoreboard of expected
//   completed-entry pulses.
module tb_keypad_entry_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int MAXD = 20;
    localparam int DV   = 4 * MAXD;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int W    = DV + 2;

    localparam logic [DV-1:0] ALL_F = {MAXD{4'hF}};
    localparam logic [DV-1:0] ALL_B = {MAXD{4'hB}};
    localparam logic [DV-1:0] ALL_E = {MAXD{4'hE}};

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic [DV-1:0]   digits_value;
    logic [CW-1:0]   digits_count;
    logic            digits_valid;
    logic [1:0]      entry_status;
    logic [2:0]      dbg_state;

    keypad_entry_scanner #(
        .ROWS(ROWS), .COLS(COLS), .MAX_DIGITS(MAXD),
        .SCAN_DIV(1), .DEBOUNCE_CYC(100), .TIMEOUT_CYC(5000)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .col_in(col_in),
        .row_out(row_out), .digits_value(digits_value),
        .digits_count(digits_count), .digits_valid(digits_valid),
        .entry_status(entry_status), .dbg_state_o(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Keypad: a held key pulls its column low while its row is driven low.
    logic       pressed = 1'b0;
    logic [1:0] press_r = 2'd0;
    logic [1:0] press_c = 2'd0;
    always_comb begin
        col_in = '1;
        if (pressed && !row_out[press_r]) col_in[press_c] = 1'b0;
    end

    // Scoreboard
    logic [W-1:0]  exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            pulse_cnt = 0;
    logic [CW-1:0] last_pulse_count = '0;
    logic          chk_next = 1'b0;
    int            model[$];

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (chk_next) begin
            chk_next = 1'b0;
            n_tests++;
            assert (digits_value === ALL_F && digits_count === '0 && digits_valid === 1'b0)
            else begin
                n_fail++;
                $error("FAIL post_pulse_clear: value=%h count=%0d valid=%b expected all F, 0, 0",
                       digits_value, digits_count, digits_valid);
            end
        end
        if (digits_valid === 1'b1) begin
            pulse_cnt++;
            last_pulse_count = digits_count;
            chk_next = 1'b1;
            n_tests++;
            assert (exp_q.size() != 0)
            else begin
                n_fail++;
                $error("FAIL unexpected_pulse: status=%b value=%h expected no pulse",
                       entry_status, digits_value);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                assert ({entry_status, digits_value} === e)
                else begin
                    n_fail++;
                    $error("FAIL pulse_payload: observed %b/%h expected %b/%h",
                           entry_status, digits_value, e[W-1 -: 2], e[DV-1:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DV-1:0] model_value();
        logic [DV-1:0] v;
        v = ALL_F;
        for (int k = 0; k < model.size(); k++) v[4*k +: 4] = 4'(model[k]);
        return v;
    endfunction

    task automatic check_buf(input string tag);
        check({tag, "_value"}, 96'(digits_value), 96'(model_value()));
        check({tag, "_count"}, 96'(digits_count), 96'(model.size()));
    endtask

    // Drivers
    task automatic press_key(input logic [1:0] r, input logic [1:0] c,
                             input int hold, input int rel);
        @(negedge clk);
        press_r = r;
        press_c = c;
        pressed = 1'b1;
        repeat (hold) @(negedge clk);
        pressed = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic key(input byte ch);
        logic [3:0] rc;
        case (ch)
            "1": rc = 4'b00_00;  "2": rc = 4'b00_01;  "3": rc = 4'b00_10;
            "4": rc = 4'b01_00;  "5": rc = 4'b01_01;  "6": rc = 4'b01_10;
            "7": rc = 4'b10_00;  "8": rc = 4'b10_01;  "9": rc = 4'b10_10;
            "*": rc = 4'b11_00;  "0": rc = 4'b11_01;  "#": rc = 4'b11_10;
            "D": rc = 4'b11_11;
            default: rc = 4'b00_11;
        endcase
        if (ch >= "0" && ch <= "9") begin
            model.push_front(int'(ch) - 48);
            if (model.size() > MAXD) void'(model.pop_back());
        end else if (ch == "D") begin
            if (model.size() > 0) void'(model.pop_front());
        end else if (ch == "*") begin
            if (model.size() > 0) begin
                exp_q.push_back({2'b00, model_value()});
                model.delete();
            end
        end else if (ch == "#") begin
            exp_q.push_back({2'b01, ALL_B});
            model.delete();
        end
        press_key(rc[3:2], rc[1:0], 150, 150);
    endtask

    initial begin
        int p0;
        int t0;
        int elapsed;
        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_row_out", 96'(row_out), 96'(4'b1110));
        check("reset_value",   96'(digits_value), 96'(ALL_F));
        check("reset_count",   96'(digits_count), 96'(0));
        check("reset_valid",   96'(digits_valid), 96'(0));
        check("reset_status",  96'(entry_status), 96'(0));
        check("reset_state",   96'(dbg_state), 96'(0));
        rst = 1'b0;

        // 1, 2, 3 then submit
        key("1"); check_buf("after_1");
        key("2"); check_buf("after_2");
        key("3"); check_buf("after_3");
        check("slots_2_0", 96'(digits_value[11:0]), 96'(12'h123));
        p0 = pulse_cnt;
        key("*");
        check("submit_pulses", 96'(pulse_cnt), 96'(p0 + 1));
        check("submit_count",  96'(last_pulse_count), 96'(3));
        check_buf("after_submit");

        // Bounce then real press of 5, then a long hold of 5
        press_key(2'd1, 2'd1, 40, 3);
        check_buf("bounce_no_insert");
        key("5"); check_buf("bounce_5");
        model.push_front(5);
        press_key(2'd1, 2'd1, 1000, 150);
        check_buf("long_hold_5");
        p0 = pulse_cnt;
        key("#");
        check("cancel_pulses", 96'(pulse_cnt), 96'(p0 + 1));
        check_buf("after_cancel");

        // 7, 8, D, 9, submit; then D on an empty buffer
        key("7"); key("8"); key("D"); key("9");
        check_buf("before_submit_79");
        check("slots_79", 96'(digits_value[7:0]), 96'(8'h79));
        key("*");
        check("submit79_count", 96'(last_pulse_count), 96'(2));
        p0 = pulse_cnt;
        key("D");
        check_buf("backspace_empty");
        check("backspace_no_pulse", 96'(pulse_cnt), 96'(p0));

        // 22 digits: overflow drops the oldest
        for (int i = 0; i < 22; i++) key(byte'(48 + (i % 10)));
        check_buf("overflow");
        check("overflow_count", 96'(digits_count), 96'(20));
        check("overflow_slot0", 96'(digits_value[3:0]), 96'(1));
        key("#");

        // Timeout with a pending digit
        key("4"); check_buf("before_timeout");
        exp_q.push_back({2'b10, ALL_E});
        p0 = pulse_cnt;
        t0 = cyc;
        for (int i = 0; i < 5300 && pulse_cnt == p0; i++) @(negedge clk);
        elapsed = cyc - t0;
        check("timeout_pulse", 96'(pulse_cnt), 96'(p0 + 1));
        check("timeout_window", 96'(elapsed >= 4800 && elapsed <= 5100), 96'(1));
        model.delete();
        repeat (2) @(negedge clk);
        check_buf("after_timeout");

        // Empty buffer never times out
        p0 = pulse_cnt;
        repeat (6000) @(negedge clk);
        check("empty_idle_no_pulse", 96'(pulse_cnt), 96'(p0));

        // Disable mid-scan: rows released, buffer held, keys ignored
        key("6");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("disabled_row_out", 96'(row_out), 96'(4'hF));
        check("disabled_state",   96'(dbg_state), 96'(4));
        check_buf("disabled_hold");
        press_key(2'd2, 2'd0, 150, 150);
        check_buf("disabled_key_ignored");
        enable = 1'b1;
        @(negedge clk);
        check("reenable_row0",  96'(row_out), 96'(4'b1110));
        check("reenable_state", 96'(dbg_state), 96'(0));

        // Reset during DEBOUNCE of key 2
        press_r = 2'd0;
        press_c = 2'd1;
        pressed = 1'b1;
        repeat (20) @(negedge clk);
        check("debounce_state", 96'(dbg_state), 96'(1));
        p0 = pulse_cnt;
        rst = 1'b1;
        #1;
        check("rst_row_out", 96'(row_out), 96'(4'b1110));
        check("rst_count",   96'(digits_count), 96'(0));
        check("rst_value",   96'(digits_value), 96'(ALL_F));
        check("rst_state",   96'(dbg_state), 96'(0));
        pressed = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model.delete();
        repeat (300) @(negedge clk);
        check("rst_no_pulse", 96'(pulse_cnt), 96'(p0));
        check_buf("after_rst");

        check("scoreboard_drained", 96'(exp_q.size()), 96'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
